instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter WORD, default 16, instruction and address width.
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum cycles imem_req may wait for imem_ack.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port run  input  1  level; fetching permitted while high.
REQ-006 SHALL have port PC_fetch  output  1  one-cycle pulse asking the program counter to present its location.
REQ-007 SHALL have port location  input  WORD  fetch address from the program counter, valid the cycle after the edge that sampled PC_fetch.
REQ-008 SHALL have port flush  input  1  jump/branch taken; discard all buffered and in-flight fetches.
REQ-009 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-010 SHALL have port imem_addr  output  WORD  read address, stable while imem_req is high.
REQ-011 SHALL have port imem_ack  input  1  read data valid on imem_rdata this cycle.
REQ-012 SHALL have port imem_rdata  input  WORD  instruction word.
REQ-013 SHALL have port instr  output  WORD  instruction at head of buffer.
REQ-014 SHALL have port instr_pc  output  WORD  address instr was fetched from.
REQ-015 SHALL have port instr_valid  output  1  buffer non-empty.
REQ-016 SHALL have port instr_ready  input  1  decode consumes head when high with instr_valid.
REQ-017 SHALL have port timeout_err  output  1  sticky memory-timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, PC_REQ, PC_LAT, MEM_REQ, STALL.
REQ-019 IDLE -> PC_REQ when run=1 and timeout_err=0; otherwise SHALL remain in IDLE.
REQ-020 PC_REQ SHALL drive PC_fetch=1 for exactly one cycle, then go to PC_LAT.
REQ-021 PC_LAT SHALL capture location into imem_addr at its ending edge, then go to MEM_REQ.
REQ-022 MEM_REQ SHALL hold imem_req=1 and imem_addr constant until imem_ack=1.
REQ-023 On imem_ack SHALL write {imem_rdata, imem_addr} into a 2-entry FIFO, unless a drop flag is set.
REQ-024 After ack: run=0 -> IDLE; FIFO full after write -> STALL; else -> PC_REQ.
REQ-025 STALL -> PC_REQ on the cycle after a pop leaves the FIFO non-full.
REQ-026 Pop SHALL occur when instr_valid and instr_ready are both high; push and pop in the same cycle SHALL be permitted at any occupancy, including full, leaving occupancy unchanged.
REQ-027 instr, instr_pc, and instr_valid SHALL be driven from registers and the FIFO head; there SHALL be no combinational path from imem_rdata to instr.
REQ-028 Minimum latency: PC_fetch edge to instr_valid SHALL be 3 cycles when imem_ack is returned in the first MEM_REQ cycle.
REQ-029 flush SHALL empty the FIFO on that edge, deassert instr_valid the next cycle, and send PC_REQ, PC_LAT, or STALL to PC_REQ.
REQ-030 flush in MEM_REQ SHALL set the drop flag; the FSM SHALL keep imem_req until imem_ack, discard that data, clear the flag, then go to PC_REQ.
REQ-031 flush and imem_ack in the same cycle SHALL discard the acked data.
REQ-032 flush SHALL take priority over a same-cycle pop.
REQ-033 A 4-bit wait counter SHALL clear on MEM_REQ entry and increment each cycle without ack.
REQ-034 When the wait counter reaches TIMEOUT without ack, the block SHALL set timeout_err, drop imem_req, and go to IDLE.
REQ-035 timeout_err SHALL clear only on rst.
REQ-036 run falling SHALL let an in-flight request complete; it SHALL NOT abort MEM_REQ.

Reset
REQ-037 rst SHALL immediately force state IDLE, FIFO empty, drop flag and wait counter 0.
REQ-038 rst SHALL immediately force PC_fetch=0, imem_req=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0, and timeout_err=0.
REQ-039 rst asserted mid-MEM_REQ SHALL abandon the request, and an imem_ack after release SHALL be ignored in IDLE.

Verification
REQ-040 Basic fetch: run=1, location=0x0004, ack in first MEM_REQ cycle with rdata=0xA5A5, instr_ready=1 -> instr_valid 3 cycles after PC_fetch, instr=0xA5A5, instr_pc=0x0004.
REQ-041 Backpressure: instr_ready=0, three fetches -> two entries held, state STALL, PC_fetch silent; then instr_ready=1 -> entries popped in order, fetch resumes.
REQ-042 Flush in flight: flush in MEM_REQ, ack 2 cycles later with 0xDEAD -> 0xDEAD never appears on instr; next PC_fetch follows.
REQ-043 Simultaneous events: with the FIFO full, push+pop in one cycle -> count stays 2 and order is preserved; flush+pop in one cycle -> FIFO empty.
REQ-044 Timeout: never ack -> imem_req drops after 15 cycles, timeout_err=1, block stays IDLE with run=1 until rst.
REQ-045 Async reset: rst pulsed mid-clock-period during MEM_REQ -> all outputs 0 before the next edge; a late ack is ignored.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: asks the PC for an address, reads instruction memory,
// and queues {instruction, address} pairs in a 2-entry buffer for decode.
module instr_fetch #(
  parameter int WORD    = 16,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            PC_fetch,
  input  logic [WORD-1:0] location,
  input  logic            flush,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [WORD-1:0] imem_rdata,
  output logic [WORD-1:0] instr,
  output logic [WORD-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            timeout_err
);

  typedef enum logic [2:0] {IDLE, PC_REQ, PC_LAT, MEM_REQ, STALL} state_t;

  localparam logic [3:0] WaitLast = 4'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            pc_fetch_q, pc_fetch_d;
  logic            imem_req_q, imem_req_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic            err_q, err_d;
  logic            drop_q, drop_d;
  logic [3:0]      wait_q, wait_d;

  logic [WORD-1:0] data_q [2];
  logic [WORD-1:0] data_d [2];
  logic [WORD-1:0] pcs_q  [2];
  logic [WORD-1:0] pcs_d  [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      count_q, count_d;

  logic            push, pop, full_if_push;

  // flush wins over a same-cycle pop, so a flushed head is never consumed
  assign pop          = (count_q != 2'd0) && instr_ready && !flush;
  assign full_if_push = pop ? (count_q == 2'd2) : (count_q == 2'd1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    drop_d  = drop_q;
    wait_d  = wait_q;
    push    = 1'b0;
    case (state_q)
      IDLE:    if (run && !err_q) state_d = PC_REQ;
      PC_REQ:  state_d = flush ? PC_REQ : PC_LAT;
      PC_LAT: begin
        if (flush) begin
          state_d = PC_REQ;
        end else begin
          addr_d  = location;
          wait_d  = 4'd0;
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (imem_ack) begin
          drop_d = 1'b0;
          if (drop_q || flush) begin
            state_d = PC_REQ;
          end else begin
            push = (count_q != 2'd2) || pop;
            if (!run)              state_d = IDLE;
            else if (full_if_push) state_d = STALL;
            else                   state_d = PC_REQ;
          end
        end else if (wait_q == WaitLast) begin
          err_d   = 1'b1;
          drop_d  = 1'b0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 4'd1;
          if (flush) drop_d = 1'b1;
        end
      end
      STALL:   if (flush || pop) state_d = PC_REQ;
      default: state_d = IDLE;
    endcase
    pc_fetch_d = (state_d == PC_REQ);
    imem_req_d = (state_d == MEM_REQ);
  end

  always_comb begin
    data_d   = data_q;
    pcs_d    = pcs_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = imem_rdata;
        pcs_d[wr_ptr_q]  = addr_q;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_fetch_q <= 1'b0;
      imem_req_q <= 1'b0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      wait_q     <= 4'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_fetch_q <= pc_fetch_d;
      imem_req_q <= imem_req_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      wait_q     <= wait_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      pcs_q      <= pcs_d;
    end
  end

  assign PC_fetch    = pc_fetch_q;
  assign imem_req    = imem_req_q;
  assign imem_addr   = addr_q;
  assign timeout_err = err_q;
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = pcs_q[rd_ptr_q];
  assign instr_valid = (count_q != 2'd0);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run scored against
// a queue-based model of the decode buffer.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        PC_fetch;
  logic [15:0] location = '0;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  bit sawDead = 0;

  instr_fetch #(.WORD(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .PC_fetch(PC_fetch), .location(location),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (instr_valid && instr == 16'hDEAD) sawDead = 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst = 1; run = 0; flush = 0; imem_ack = 0; instr_ready = 0;
    location = '0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic waitFetch(input string tag);
    int n = 0;
    while (!PC_fetch && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, 32'(PC_fetch), 32'd1);
  endtask

  // Called at the negedge where PC_fetch is high; returns just after the ack edge.
  task automatic doFetch(input logic [15:0] loc, input logic [15:0] data,
                         input int delay, input bit rdyAtAck);
    logic oldRdy;
    location = loc;
    stepCycle();
    stepCycle();
    checkOutput("req_high", 32'(imem_req), 32'd1);
    checkOutput("req_addr", 32'(imem_addr), 32'(loc));
    repeat (delay) stepCycle();
    imem_ack = 1; imem_rdata = data;
    oldRdy = instr_ready;
    if (rdyAtAck) instr_ready = 1;
    stepCycle();
    imem_ack = 0; instr_ready = oldRdy;
  endtask

  // Randomized run: the bench acts as PC and memory, and tracks the expected
  // buffer contents as a queue of {instruction, address}.
  task automatic applyStimulus(input int cycles);
    logic [15:0] qd[$];
    logic [15:0] qp[$];
    bit dropped = 0, reqActive = 0;
    int delay = 0, waited = 0, pops = 0;
    logic [15:0] expAddr = '0;
    bit fl, rdy, ak, doPop, doPush;
    logic [15:0] dat;
    applyReset();
    run = 1;
    for (int c = 0; c < cycles; c++) begin
      checkOutput("rnd_valid", 32'(instr_valid), 32'(qd.size() != 0));
      if (qd.size() != 0) begin
        checkOutput("rnd_instr", 32'(instr), 32'(qd[0]));
        checkOutput("rnd_pc", 32'(instr_pc), 32'(qp[0]));
      end
      if (PC_fetch) begin
        checkOutput("rnd_fetch_room", 32'(qd.size() < 2), 32'd1);
        location = 16'($urandom);
        expAddr = location;
      end
      fl  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      ak  = 0;
      dat = 16'($urandom);
      if (imem_req) begin
        if (!reqActive) begin
          reqActive = 1;
          delay = $urandom_range(0, 4);
          waited = 0;
          checkOutput("rnd_addr", 32'(imem_addr), 32'(expAddr));
        end
        if (waited == delay) ak = 1;
        else waited++;
      end else begin
        reqActive = 0;
      end
      doPop  = instr_valid && rdy && !fl;
      doPush = ak && !dropped && !fl;
      if (fl) begin
        qd.delete(); qp.delete();
        if (imem_req && !ak) dropped = 1;
      end else begin
        if (doPop) begin
          void'(qd.pop_front()); void'(qp.pop_front());
          pops++;
        end
        if (doPush) begin
          qd.push_back(dat); qp.push_back(expAddr);
        end
      end
      if (ak) dropped = 0;
      flush = fl; instr_ready = rdy; imem_ack = ak; imem_rdata = dat;
      stepCycle();
    end
    flush = 0; imem_ack = 0;
    checkOutput("rnd_throughput", 32'(pops > 200), 32'd1);
    checkOutput("rnd_no_timeout", 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int n;

    // reset state
    applyReset();
    checkOutput("rst_pcf", 32'(PC_fetch), 32'd0);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_instr", 32'(instr), 32'd0);
    checkOutput("rst_ipc", 32'(instr_pc), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_err", 32'(timeout_err), 32'd0);

    // basic fetch and three-cycle latency
    run = 1; instr_ready = 1;
    waitFetch("basic_fetch");
    location = 16'h0004;
    stepCycle();
    stepCycle();
    checkOutput("basic_lat2_valid", 32'(instr_valid), 32'd0);
    checkOutput("basic_addr", 32'(imem_addr), 32'h0004);
    imem_ack = 1; imem_rdata = 16'hA5A5;
    stepCycle();
    imem_ack = 0;
    checkOutput("basic_lat3_valid", 32'(instr_valid), 32'd1);
    checkOutput("basic_instr", 32'(instr), 32'hA5A5);
    checkOutput("basic_pc", 32'(instr_pc), 32'h0004);

    // backpressure, push+pop at ack, flush+pop while full
    applyReset();
    run = 1; instr_ready = 0;
    waitFetch("bp_fetch1");
    doFetch(16'h0010, 16'hAAA1, 0, 0);
    waitFetch("bp_fetch2");
    doFetch(16'h0011, 16'hAAA2, 1, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (PC_fetch || imem_req) n++;
      stepCycle();
    end
    checkOutput("bp_silent", 32'(n), 32'd0);
    checkOutput("bp_head", 32'(instr), 32'hAAA1);
    checkOutput("bp_head_pc", 32'(instr_pc), 32'h0010);
    instr_ready = 1;
    stepCycle();
    instr_ready = 0;
    checkOutput("bp_resume", 32'(PC_fetch), 32'd1);
    checkOutput("bp_second", 32'(instr), 32'hAAA2);
    checkOutput("bp_second_pc", 32'(instr_pc), 32'h0011);
    doFetch(16'h0012, 16'hAAA3, 0, 1);
    checkOutput("pp_valid", 32'(instr_valid), 32'd1);
    checkOutput("pp_head", 32'(instr), 32'hAAA3);
    checkOutput("pp_head_pc", 32'(instr_pc), 32'h0012);
    waitFetch("pp_fetch");
    doFetch(16'h0013, 16'hAAA4, 0, 0);
    checkOutput("full_head", 32'(instr), 32'hAAA3);
    instr_ready = 1; flush = 1;
    stepCycle();
    flush = 0; instr_ready = 0;
    checkOutput("flpop_valid", 32'(instr_valid), 32'd0);
    checkOutput("flpop_refetch", 32'(PC_fetch), 32'd1);
    doFetch(16'h0014, 16'hAAA5, 0, 0);
    checkOutput("flpop_next", 32'(instr), 32'hAAA5);
    checkOutput("flpop_next_pc", 32'(instr_pc), 32'h0014);

    // flush while the memory read is in flight
    applyReset();
    sawDead = 0;
    run = 1; instr_ready = 1;
    waitFetch("fl_fetch");
    location = 16'h0100;
    stepCycle();
    stepCycle();
    flush = 1;
    stepCycle();
    flush = 0;
    checkOutput("fl_req_held", 32'(imem_req), 32'd1);
    stepCycle();
    imem_ack = 1; imem_rdata = 16'hDEAD;
    stepCycle();
    imem_ack = 0;
    checkOutput("fl_dropped_valid", 32'(instr_valid), 32'd0);
    checkOutput("fl_refetch", 32'(PC_fetch), 32'd1);
    doFetch(16'h0200, 16'h1234, 1, 0);
    checkOutput("fl_next", 32'(instr), 32'h1234);
    checkOutput("fl_no_dead", 32'(sawDead), 32'd0);

    // memory timeout
    applyReset();
    run = 1;
    waitFetch("to_fetch");
    stepCycle();
    stepCycle();
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      stepCycle();
    end
    checkOutput("to_req_cycles", 32'(n), 32'd15);
    checkOutput("to_err", 32'(timeout_err), 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (PC_fetch || imem_req) n++;
      stepCycle();
    end
    checkOutput("to_idle", 32'(n), 32'd0);
    checkOutput("to_sticky", 32'(timeout_err), 32'd1);
    applyReset();
    checkOutput("to_cleared", 32'(timeout_err), 32'd0);

    // asynchronous reset during a request, then a late ack
    run = 1; instr_ready = 0;
    waitFetch("ar_fetch1");
    doFetch(16'h0030, 16'h7777, 0, 0);
    waitFetch("ar_fetch2");
    location = 16'h0031;
    stepCycle();
    stepCycle();
    checkOutput("ar_req", 32'(imem_req), 32'd1);
    #2 rst = 1;
    #1;
    checkOutput("ar_pcf", 32'(PC_fetch), 32'd0);
    checkOutput("ar_req0", 32'(imem_req), 32'd0);
    checkOutput("ar_addr", 32'(imem_addr), 32'd0);
    checkOutput("ar_instr", 32'(instr), 32'd0);
    checkOutput("ar_ipc", 32'(instr_pc), 32'd0);
    checkOutput("ar_valid", 32'(instr_valid), 32'd0);
    checkOutput("ar_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst = 0; run = 0;
    imem_ack = 1; imem_rdata = 16'hBEEF;
    stepCycle();
    imem_ack = 0;
    checkOutput("ar_late_valid", 32'(instr_valid), 32'd0);
    checkOutput("ar_late_req", 32'(imem_req), 32'd0);
    stepCycle();
    checkOutput("ar_late_pcf", 32'(PC_fetch), 32'd0);

    // randomized run against the buffer model
    applyStimulus(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
